// File: rtl/pool2x2_relu.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU clamp on the input side.
// One half-row line buffer carries pair maxima from even rows to odd rows.
module pool2x2_relu #(
  parameter int map_width     = 8,
  parameter int total_bits    = 16,
  parameter int fraction_bits = 12,
  parameter bit relu_en       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [total_bits-1:0] in_data,
  input  logic                  in_valid,
  output logic [total_bits-1:0] out_data,
  output logic                  out_valid,
  output logic                  frame_done
);

  localparam int half   = map_width / 2;
  localparam int cnt_w  = (map_width > 2) ? $clog2(map_width) : 1;
  localparam int lb_aw  = (half > 1) ? $clog2(half) : 1;
  localparam bit odd_map = (map_width % 2) == 1;
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(map_width - 1);

  typedef logic [total_bits-1:0] word_t;

  function automatic word_t smax(input word_t a, input word_t b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [cnt_w-1:0] col, row;
  word_t            h;
  word_t            line_buf [half];
  word_t            x, pair, lb_rd;
  logic [lb_aw-1:0] lb_idx;
  logic             last_col, last_row, in_window, pair_done;

  assign x         = (relu_en && in_data[total_bits-1]) ? '0 : in_data;
  assign pair      = smax(h, x);
  assign last_col  = (col == last_idx);
  assign last_row  = (row == last_idx);
  // With an odd width the trailing column/row never completes a window.
  assign in_window = !(odd_map && (last_col || last_row));
  assign pair_done = in_valid && col[0] && in_window;
  assign lb_idx    = lb_aw'(col >> 1);
  assign lb_rd     = line_buf[lb_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      h          <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) h <= x;
        if (pair_done && row[0]) begin
          out_data  <= smax(lb_rd, pair);
          out_valid <= 1'b1;
        end
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Every entry is rewritten on an even row before an odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (pair_done && !row[0]) line_buf[lb_idx] <= pair;
  end

endmodule

// File: tb/tb_pool2x2_relu.sv
// Scoreboard bench for pool2x2_relu: three instances (w8 relu, w8 bypass, w7 relu)
// share one input stream; a frame-array model predicts outputs, a monitor compares.
module tb_pool2x2_relu;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] od [3];
  logic        ov [3];
  logic        fd [3];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  exp_t               exp_q [3][$];
  int                 fd_q  [3][$];
  logic signed [15:0] pix   [3][64];
  logic [15:0]        last  [3];
  int                 kcnt  [3];
  int                 wid   [3] = '{8, 8, 7};
  bit                 rel   [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pool2x2_relu #(.map_width(8), .total_bits(16), .fraction_bits(12), .relu_en(1'b1)) u_r8 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .frame_done(fd[0]));
  pool2x2_relu #(.map_width(8), .total_bits(16), .fraction_bits(12), .relu_en(1'b0)) u_n8 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .frame_done(fd[1]));
  pool2x2_relu #(.map_width(7), .total_bits(16), .fraction_bits(12), .relu_en(1'b1)) u_r7 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[2]), .out_valid(ov[2]), .frame_done(fd[2]));

  // Reference: place each accepted sample in a frame array; a window completes at
  // its bottom-right pixel and its max is due on the following clock edge.
  task automatic model_sample(input logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      int w, k, r, c, p;
      logic signed [15:0] x, m;
      w = wid[i];
      k = kcnt[i];
      r = k / w;
      c = k % w;
      x = (rel[i] && d[15]) ? 16'sd0 : $signed(d);
      pix[i][r*8+c] = x;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < (w/2)*2) && (c < (w/2)*2)) begin
        m = pix[i][(r-1)*8 + c-1];
        for (int j = 1; j < 4; j++) begin
          p = (r - 1 + j/2) * 8 + (c - 1 + j%2);
          if (pix[i][p] > m) m = pix[i][p];
        end
        exp_q[i].push_back('{cyc + 1, m});
      end
      if (k == w*w - 1) begin
        fd_q[i].push_back(cyc + 1);
        kcnt[i] = 0;
      end else begin
        kcnt[i] = k + 1;
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input int duty);
    while ($urandom_range(99) >= duty) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    model_sample(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 16'h0 || fd[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got valid=%b data=%h done=%b, need 0/0000/0",
                 i, ov[i], od[i], fd[i]);
      end
      exp_q[i].delete();
      fd_q[i].delete();
      kcnt[i] = 0;
      last[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_dut(input int i);
    bit   exp_v, exp_fd;
    exp_t e;
    exp_v = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == cyc);
    checks++;
    if (ov[i] !== exp_v) begin
      errors++;
      $display("FAIL out_valid dut%0d cyc%0d: got %b, need %b", i, cyc, ov[i], exp_v);
    end
    if (exp_v) begin
      e = exp_q[i].pop_front();
      last[i] = e.data;
    end
    checks++;
    if (od[i] !== last[i]) begin
      errors++;
      $display("FAIL out_data dut%0d cyc%0d: got %h, need %h", i, cyc, od[i], last[i]);
    end
    exp_fd = (fd_q[i].size() > 0) && (fd_q[i][0] == cyc);
    if (exp_fd) void'(fd_q[i].pop_front());
    checks++;
    if (fd[i] !== exp_fd) begin
      errors++;
      $display("FAIL frame_done dut%0d cyc%0d: got %b, need %b", i, cyc, fd[i], exp_fd);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      last[i] = '0;
      kcnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) check_dut(i);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] frame [64];
    do_reset();

    // Plain ramp: w8 yields 16r+2c+9, w7 sees a frame plus part of the next.
    for (int v = 0; v < 64; v++) send(16'(v), 100);
    idle(2);

    // Two back-to-back 7x7 ramps.
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int v = 0; v < 49; v++) send(16'(v), 100);
    idle(2);

    // All -1.0: clamp on relu instances, passthrough on bypass instance.
    do_reset();
    for (int v = 0; v < 64; v++) send(16'hF000, 100);
    idle(1);

    // Signed-compare corner windows, remaining pixels random.
    for (int v = 0; v < 64; v++) frame[v] = 16'($urandom);
    frame[0]  = 16'h7FFF; frame[1]  = 16'h8000; frame[8]  = 16'h0001; frame[9]  = 16'hFFFF;
    frame[2]  = 16'h8000; frame[3]  = 16'h8001; frame[10] = 16'hFFFE; frame[11] = 16'h8002;
    do_reset();
    for (int v = 0; v < 64; v++) send(frame[v], 100);

    // Gappy ramp at ~40% duty.
    do_reset();
    for (int v = 0; v < 64; v++) send(16'(v), 40);
    idle(3);

    // Random frames with random gaps.
    do_reset();
    for (int n = 0; n < 3; n++)
      for (int v = 0; v < 64; v++) send(16'($urandom), 70);
    idle(3);

    // Reset mid-frame then a fresh ramp must produce no stale window.
    for (int v = 0; v < 20; v++) send(16'(v), 100);
    do_reset();
    for (int v = 0; v < 64; v++) send(16'(v), 100);
    idle(4);

    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0 || fd_q[i].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: %0d outputs and %0d frame_done still pending, need 0",
                 i, exp_q[i].size(), fd_q[i].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool2x2_relu.md
# pool2x2_relu

Streaming 2×2, stride-2 max-pool stage with optional ReLU. It sits directly downstream of `conv_layer` and consumes its `conv_op`/`valid_conv` stream, one fixed-point convolution result per valid cycle in row-major order. It emits one pooled value per 2×2 window to the next layer. A single half-row line buffer holds partial results, so the stage never stalls the convolution.

## Interface
- `map_width`, 8: width and height of the incoming square feature map. Equals activation_map − kernel + 1 for stride 1. Must be ≥ 2.
- `total_bits`, 16: data width; two's-complement signed fixed point.
- `fraction_bits`, 12: fraction bits. Carried for consistency only; pooling does no rescaling.
- `relu_en`, 1: 1 clamps negative inputs to 0 before pooling; 0 bypasses the clamp.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_data`  in  total_bits  convolution result (connects to `conv_op`).
- `in_valid`  in  1  `in_data` is valid this cycle (connects to `valid_conv`).
- `out_data`  out  total_bits  pooled value; holds its last value between pulses.
- `out_valid`  out  1  one-cycle pulse per completed window.
- `frame_done`  out  1  one-cycle pulse after the final input of a frame.

## Operation
- Counters:
  - `col` runs 0..map_width−1; `row` runs 0..map_width−1.
  - Both advance only on cycles with `in_valid`=1.
  - `col` wraps to 0 and increments `row`. `row` wraps to 0 after the last column of the last row (frame wrap).
- Pre-stage: x = (`relu_en` && `in_data`[MSB]) ? 0 : `in_data`.
- All comparisons are signed, full width. Ties select either value (they are identical).
- Even `col`: x is latched into a horizontal hold register `h`.
- Odd `col`: pair = max(h, x).
- Even `row`: pair is written to `line_buf[col>>1]`. Depth is floor(map_width/2) entries of total_bits.
- Odd `row`:
  - `out_data` ← max(`line_buf[col>>1]`, pair) and `out_valid` pulses.
  - The line buffer is not written.
- Odd `map_width`: the last column and the last row are ignored (floor pooling). They still advance the counters but produce no output and no buffer write.
- Outputs per frame: floor(map_width/2)² values, in row-major window order.
- `frame_done` pulses once per frame. Counters then restart at (0,0) with no idle cycle needed, so back-to-back frames are supported.
- No backpressure: downstream must accept every `out_valid` pulse.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `frame_done`=0, `col`=0, `row`=0, `h`=0.
- Line buffer contents are don't-care after reset, because every entry is written on an even row before it is read.
- Latency: `out_valid` is asserted the cycle after the `in_valid` cycle that carries the bottom-right pixel of the window. `out_data` is valid in that same cycle.
- `frame_done` is asserted the cycle after the `in_valid` cycle at (`row`,`col`) = (map_width−1, map_width−1). For even map_width it coincides with the last `out_valid`.
- `in_valid` may have arbitrary gaps, including multi-cycle idle between rows. Outputs depend only on the accepted-sample count, never on cycle count.
- A new input may arrive in the same cycle that `out_valid` or `frame_done` is high. No bubble is required.
- Reset asserted mid-frame:
  - All outputs drop to 0 asynchronously.
  - The partial frame is discarded.
  - The first valid input after release is treated as (0,0).

## Test plan
- Ramp, `relu_en`=1, map_width=8: inputs 0..63 (raw integers) -> 16 outputs. Row r, col c of the output = 16r+2c+9 (e.g. 9, 11, 13, 15, 25, …, 63). `frame_done` pulses with the 16th output.
- All-negative frame, `relu_en`=1: 64 × 0xF000 (−1.0) -> 16 outputs of 0x0000. With `relu_en`=0 -> 16 outputs of 0xF000.
- Signed compare: a window of {0x7FFF, 0x8000, 0x0001, 0xFFFF} with `relu_en`=0 -> 0x7FFF. The window {0x8000, 0x8001, 0xFFFE, 0x8002} -> 0xFFFE.
- Gappy input: ramp 0..63 with `in_valid` toggling randomly at ~40% duty -> the same 16 values as the ramp test, each 1 cycle after its enabling sample.
- Odd map, map_width=7: ramp 0..48 -> 9 outputs = 8, 10, 12, 22, 24, 26, 36, 38, 40. `frame_done` pulses 1 cycle after sample 48. A second ramp immediately afterwards repeats the sequence.
- Reset mid-frame: after 20 samples of a ramp, pulse `reset`, then send a fresh ramp 0..63 -> `out_valid` and `out_data` go to 0 during reset, and exactly the 16 ramp outputs follow with no stale window.
